// File: rtl/sram_stream_fifo.sv
// Valid/ready stream FIFO over an external 64x144 two-port SRAM with a 2-entry output prefetch buffer.
// Optional watermark flag built only when SRAM_FIFO_WM_EN is defined.
module sram_stream_fifo #(
    parameter int DW    = 144,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW+1:0] count,
    output logic          ram_wceb,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rceb,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    input  logic [AW+1:0] wm_level,
    output logic          wm_hit
);

    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_ram_cnt;
    logic          r_inflight;
    logic [DW-1:0] r_obuf [2];
    logic [1:0]    r_obuf_cnt;

    logic          w_push, w_pop, w_rd;
    logic [2:0]    w_occ;
    logic [1:0]    w_after_pop;
    logic [AW-1:0] w_wptr_n, w_rptr_n;
    logic [AW:0]   w_ram_cnt_n;
    logic [1:0]    w_obuf_cnt_n;
    logic [DW-1:0] w_obuf0_n, w_obuf1_n;
    logic [AW+1:0] w_count_n;

    assign s_ready   = (r_ram_cnt < (AW+1)'(DEPTH));
    assign m_valid   = (r_obuf_cnt != 2'd0);
    assign m_data    = r_obuf[0];
    assign count     = (AW+2)'(r_ram_cnt) + (AW+2)'(r_inflight) + (AW+2)'(r_obuf_cnt);
    assign ram_wceb  = ~w_push;
    assign ram_waddr = r_wptr;
    assign ram_wdata = s_data;
    assign ram_rceb  = ~w_rd;
    assign ram_raddr = r_rptr;

    assign w_push = s_valid & s_ready & ~rst;
    assign w_pop  = m_valid & m_ready;
    // Entries already held or on their way back, minus the one leaving now, must leave a free slot.
    assign w_occ  = {1'b0, r_obuf_cnt} + {2'b00, r_inflight};
    assign w_rd   = ~rst & (r_ram_cnt != '0) & ((w_occ - {2'b00, w_pop}) < 3'd2);
    assign w_after_pop = r_obuf_cnt - {1'b0, w_pop};

    always_comb begin
        w_wptr_n     = w_push ? ((r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1) : r_wptr;
        w_rptr_n     = w_rd   ? ((r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1) : r_rptr;
        w_ram_cnt_n  = r_ram_cnt + (AW+1)'(w_push) - (AW+1)'(w_rd);
        w_obuf_cnt_n = w_after_pop + {1'b0, r_inflight};
        w_obuf0_n    = r_obuf[0];
        w_obuf1_n    = r_obuf[1];
        // Head shifts only when a second entry exists, so an emptied buffer keeps its last word.
        if (w_pop && r_obuf_cnt == 2'd2)
            w_obuf0_n = r_obuf[1];
        if (r_inflight) begin
            if (w_after_pop == 2'd0)
                w_obuf0_n = ram_rdata;
            else
                w_obuf1_n = ram_rdata;
        end
        w_count_n = (AW+2)'(w_ram_cnt_n) + (AW+2)'(w_rd) + (AW+2)'(w_obuf_cnt_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_obuf[0]  <= '0;
            r_obuf[1]  <= '0;
            r_obuf_cnt <= '0;
        end else begin
            r_wptr     <= w_wptr_n;
            r_rptr     <= w_rptr_n;
            r_ram_cnt  <= w_ram_cnt_n;
            r_inflight <= w_rd;
            r_obuf[0]  <= w_obuf0_n;
            r_obuf[1]  <= w_obuf1_n;
            r_obuf_cnt <= w_obuf_cnt_n;
        end
    end

`ifdef SRAM_FIFO_WM_EN
    logic r_wm_hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wm_hit <= 1'b0;
        else
            r_wm_hit <= (w_count_n >= wm_level);
    end
    assign wm_hit = r_wm_hit;
`else
    logic          w_unused;
    logic [AW+1:0] w_unused_cnt;
    assign w_unused     = ^wm_level;
    assign w_unused_cnt = w_count_n;
    assign wm_hit       = 1'b0;
`endif

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Randomized and directed bench for sram_stream_fifo against a queue-level model, with an SRAM model attached.
module tb_sram_stream_fifo;

    localparam int DW    = 144;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data, ram_wdata, ram_rdata;
    logic [AW+1:0] count, wm_level;
    logic          ram_wceb, ram_rceb, wm_hit;
    logic [AW-1:0] ram_waddr, ram_raddr;

    always #5 clk = ~clk;

    sram_stream_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_wceb(ram_wceb), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_rceb(ram_rceb), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .wm_level(wm_level), .wm_hit(wm_hit)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
        if (!ram_rceb) ram_rdata <= mem[ram_raddr];
    end

    // Model: words sit in the RAM, then one may be in flight, then up to two wait at the output.
    logic [DW-1:0] ram_q[$], fly_q[$], ob_q[$], sb_q[$];
    logic [DW-1:0] last_out;
    int            mwptr, mrptr;
    logic          wm_exp;
    int            n_pass = 0, n_tot = 0;
    int            cyc = 0;
    int            accepted;
    logic          seen_mvalid;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic model_clear();
        ram_q.delete(); fly_q.delete(); ob_q.delete(); sb_q.delete();
        last_out = '0; mwptr = 0; mrptr = 0; wm_exp = 1'b0;
    endtask

    // One clock: drive at negedge, compare 1 ns later, then advance the model past the next posedge.
    task automatic cycle(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
        bit pop, acc, rd;
        int cnt;
        @(negedge clk);
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        cyc++;
        if (r) model_clear();
        acc = !r && sv && (ram_q.size() < DEPTH);
        pop = !r && (ob_q.size() > 0) && mr;
        rd  = !r && (ram_q.size() > 0) && (ob_q.size() + fly_q.size() - int'(pop) < 2);
        cnt = ram_q.size() + fly_q.size() + ob_q.size();
        seen_mvalid = m_valid;
        chk("s_ready",  {143'b0, s_ready},  {143'b0, (ram_q.size() < DEPTH)});
        chk("m_valid",  {143'b0, m_valid},  {143'b0, (ob_q.size() > 0)});
        chk("m_data",   m_data,             (ob_q.size() > 0) ? ob_q[0] : last_out);
        chk("count",    DW'(count),         DW'(cnt));
        chk("ram_wceb", {143'b0, ram_wceb}, {143'b0, !acc});
        chk("ram_rceb", {143'b0, ram_rceb}, {143'b0, !rd});
        chk("ram_waddr", DW'(ram_waddr),    DW'(mwptr));
        chk("ram_raddr", DW'(ram_raddr),    DW'(mrptr));
        chk("ram_wdata", ram_wdata,         sd);
        chk("wm_hit",   {143'b0, wm_hit},   {143'b0, wm_exp});
        if (pop) begin
            chk("scoreboard", m_data, sb_q.pop_front());
            last_out = ob_q.pop_front();
        end
        if (fly_q.size() > 0 && !r) ob_q.push_back(fly_q.pop_front());
        if (rd) begin
            fly_q.push_back(ram_q.pop_front());
            mrptr = (mrptr + 1) % DEPTH;
        end
        if (acc) begin
            ram_q.push_back(sd);
            sb_q.push_back(sd);
            mwptr = (mwptr + 1) % DEPTH;
            accepted++;
        end
`ifdef SRAM_FIFO_WM_EN
        if (!r) wm_exp = ((ram_q.size() + fly_q.size() + ob_q.size()) >= int'(wm_level));
`endif
    endtask

    task automatic drain();
        int guard = 0;
        while ((ram_q.size() + fly_q.size() + ob_q.size()) > 0 && guard < 300) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_bound", DW'(guard < 300), DW'(1));
    endtask

    initial begin
        int t0, lat, hits, sent;
        logic [DW-1:0] a5;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        wm_level = 8'd10;
        model_clear();
        ram_rdata = '0;
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("reset_count",   DW'(count),   DW'(0));
        chk("reset_m_valid", DW'(m_valid), DW'(0));
        chk("reset_s_ready", DW'(s_ready), DW'(1));

        // Fill with consumer stalled: RAM plus two buffer slots.
        accepted = 0;
        for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, rnd_word(), 1'b0);
        chk("fill_accepted", DW'(accepted), DW'(66));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("full_count",   DW'(count),    DW'(66));
        chk("full_s_ready", DW'(s_ready),  DW'(0));
        chk("full_rceb",    DW'(ram_rceb), DW'(1));
        drain();

        // Single word latency into an empty FIFO.
        a5 = DW'(8'hA5);
        cycle(1'b0, 1'b1, a5, 1'b1);
        t0 = cyc; lat = -1; hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (seen_mvalid) begin
                hits++;
                if (lat < 0) lat = cyc - t0;
                chk("latency_data", m_data, a5);
            end
        end
        chk("latency_cycles", DW'(lat),  DW'(3));
        chk("latency_once",   DW'(hits), DW'(1));

        // Continuous streaming of incrementing words.
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, DW'(i + 1), 1'b1);
            if (i == 100) chk("stream_count", DW'(count), DW'(3));
        end
        drain();

        // Random stalls on both sides; pointers wrap many times.
        sent = 0;
        for (int i = 0; i < 6000 && sent < 1000; i++) begin
            logic sv;
            sv = ($urandom_range(99) >= 30) && (sent < 1000);
            if (sv && ram_q.size() < DEPTH) sent++;
            cycle(1'b0, sv, rnd_word(), ($urandom_range(99) >= 30));
        end
        chk("random_sent", DW'(sent), DW'(1000));
        drain();

        // Reset while a read is in flight and the buffer is occupied.
        for (int i = 0; i < 10 && !(fly_q.size() == 1 && ob_q.size() == 1); i++)
            cycle(1'b0, 1'b1, rnd_word(), 1'b0);
        chk("pre_reset_state", DW'(fly_q.size() * 2 + ob_q.size()), DW'(3));
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("midreset_count",   DW'(count),    DW'(0));
        chk("midreset_m_valid", DW'(m_valid),  DW'(0));
        chk("midreset_ceb",     DW'({ram_wceb, ram_rceb}), DW'(3));
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, DW'(144'h5A5A), 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("post_reset_word", last_out, DW'(144'h5A5A));

        // Watermark crossing at level 10.
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, rnd_word(), 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
